// File: rtl/id_stage_q.sv
// RV32I decode stage: combinational decode into a DEPTH-entry output queue with valid/ready on both sides.
// Optional illegal-instruction marking is compiled in with `define ID_ILLEGAL_TRAP_EN.
module id_stage_q #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_inst_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_alu_src_1,
  output logic             out_alu_src_2,
  output logic [31:0]      out_alu_imm_1,
  output logic [31:0]      out_alu_imm_2,
  output logic [7:0]       out_alu_op,
  output logic [7:0]       out_mem_op,
  output logic [7:0]       out_csr_op,
  output logic             out_gpr_we,
  output logic             out_load,
  output logic             out_store,
  output logic             out_illegal,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] USED_EN = 32'h3B00_3131;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alu_src_1;
    logic        alu_src_2;
    logic [31:0] alu_imm_1;
    logic [31:0] alu_imm_2;
    logic [7:0]  alu_op;
    logic [7:0]  mem_op;
    logic [7:0]  csr_op;
    logic        gpr_we;
    logic        load;
    logic        store;
    logic        illegal;
  } entry_t;

  localparam entry_t IDLE = '{pc: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                              alu_src_1: 1'b0, alu_src_2: 1'b0,
                              alu_imm_1: 32'd0, alu_imm_2: 32'd0,
                              alu_op: 8'hFF, mem_op: 8'hFF, csr_op: 8'hFF,
                              gpr_we: 1'b1, load: 1'b1, store: 1'b1, illegal: 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_imm, is_reg, is_load, is_store, is_csr;
  logic csrrw, csrrs, csrrc, sys0;
  logic [2:0]  f3;
  logic [31:0] imm_u, imm_i, imm_s, imm_sel;
  logic        unused_bits;
  entry_t      dec;

  assign is_lui    = ~in_inst_enable[13];
  assign is_auipc  = ~in_inst_enable[5];
  assign is_jal    = ~in_inst_enable[27];
  assign is_jalr   = ~in_inst_enable[25];
  assign is_branch = ~in_inst_enable[24];
  assign is_imm    = ~in_inst_enable[4];
  assign is_reg    = ~in_inst_enable[12];
  assign is_load   = ~in_inst_enable[0];
  assign is_store  = ~in_inst_enable[8];
  assign is_csr    = ~in_inst_enable[28];

  assign f3    = in_inst[14:12];
  assign sys0  = is_csr & (f3 == 3'd0);
  assign csrrw = is_csr & (f3[1:0] == 2'b01);
  assign csrrs = is_csr & (f3[1:0] == 2'b10);
  assign csrrc = is_csr & (f3[1:0] == 2'b11);

  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};

  // Opcode comes from the fetch-side enables, so the raw opcode bits are not decoded here.
  assign unused_bits = ^{in_inst_enable & ~USED_EN, in_inst[6:0]};

  always_comb begin
    imm_sel = 32'd0;
    if (is_lui | is_auipc)                     imm_sel = imm_u;
    else if (is_load | is_imm | is_jalr | is_jal) imm_sel = imm_i;
    else if (is_store)                          imm_sel = imm_s;

    dec           = IDLE;
    dec.pc        = in_pc;
    dec.rd        = in_inst[11:7];
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.alu_src_1 = ~(is_load | is_store | is_imm | is_reg | is_branch);
    dec.alu_src_2 = ~(is_reg | is_branch);
    dec.alu_imm_1 = (is_auipc | is_jal | is_jalr) ? in_pc : 32'd0;
    dec.alu_imm_2 = (is_jal | is_jalr) ? 32'd4 : imm_sel;

    if (is_lui | is_auipc | is_jal | is_jalr | is_load | is_store) dec.alu_op = 8'hFB;
    else if (is_branch) dec.alu_op = 8'hFA;
    else if (is_imm | is_reg) begin
      case (f3)
        3'd0:    dec.alu_op = (is_reg & in_inst[30]) ? 8'hFA : 8'hFB;
        3'd1:    dec.alu_op = 8'hD8;
        3'd2:    dec.alu_op = 8'h7A;
        3'd3:    dec.alu_op = 8'hBA;
        3'd4:    dec.alu_op = 8'hFC;
        3'd5:    dec.alu_op = in_inst[30] ? 8'hF0 : 8'hE8;
        3'd6:    dec.alu_op = 8'hFD;
        default: dec.alu_op = 8'hFE;
      endcase
    end else dec.alu_op = 8'hF8;

    dec.mem_op = ~{is_load & (f3 == 3'd0), is_load & (f3 == 3'd1), is_load & (f3 == 3'd2),
                   is_load & (f3 == 3'd4), is_load & (f3 == 3'd5),
                   is_store & (f3 == 3'd0), is_store & (f3 == 3'd1), is_store & (f3 == 3'd2)};
    dec.csr_op = {1'b0, ~(sys0 & (in_inst[22:20] == 3'd0)), ~(sys0 & (in_inst[22:20] == 3'd1)),
                  ~(sys0 & (in_inst[22:20] == 3'd2)), ~csrrw, ~csrrs, ~csrrc, ~in_inst[14]};
    dec.gpr_we = ~((in_inst[11:7] != 5'd0) &
                   (is_lui | is_auipc | is_jal | is_jalr | is_load | is_imm | is_reg |
                    csrrw | csrrs | csrrc));
    dec.load   = ~is_load;
    dec.store  = ~is_store;
`ifdef ID_ILLEGAL_TRAP_EN
    dec.illegal = ~(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_imm | is_reg |
                    is_load | is_store | is_csr) | (in_inst[1:0] != 2'b11);
    if (dec.illegal) begin
      dec.gpr_we      = 1'b1;
      dec.mem_op      = 8'hFF;
      dec.load        = 1'b1;
      dec.store       = 1'b1;
      dec.csr_op[7:1] = 7'h7F;
    end
`else
    dec.illegal = 1'b0;
`endif
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  entry_t           mem_q [DEPTH];
  entry_t           head;

  assign in_ready  = (cnt_q < DEPTH_C);
  assign out_valid = (cnt_q != '0);
  // Reset and flush both suppress the queue update of the same cycle.
  assign push      = in_valid & in_ready & ~flush & rst;
  assign pop       = out_valid & out_ready & ~flush & rst;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head          = out_valid ? mem_q[rd_ptr_q] : IDLE;
  assign occupancy     = cnt_q;
  assign out_pc        = head.pc;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_alu_src_1 = head.alu_src_1;
  assign out_alu_src_2 = head.alu_src_2;
  assign out_alu_imm_1 = head.alu_imm_1;
  assign out_alu_imm_2 = head.alu_imm_2;
  assign out_alu_op    = head.alu_op;
  assign out_mem_op    = head.mem_op;
  assign out_csr_op    = head.csr_op;
  assign out_gpr_we    = head.gpr_we;
  assign out_load      = head.load;
  assign out_store     = head.store;
  assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_id_stage_q.sv
// Directed bench for id_stage_q: decode vector table plus queue corner-case sequences.
module tb_id_stage_q;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, in_inst_enable;
  logic [31:0] out_pc, out_alu_imm_1, out_alu_imm_2;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_alu_src_1, out_alu_src_2, out_gpr_we, out_load, out_store, out_illegal;
  logic [7:0]  out_alu_op, out_mem_op, out_csr_op;
  logic [CNT_W-1:0] occupancy;

  id_stage_q #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_inst_enable(in_inst_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_src_1(out_alu_src_1), .out_alu_src_2(out_alu_src_2),
    .out_alu_imm_1(out_alu_imm_1), .out_alu_imm_2(out_alu_imm_2),
    .out_alu_op(out_alu_op), .out_mem_op(out_mem_op), .out_csr_op(out_csr_op),
    .out_gpr_we(out_gpr_we), .out_load(out_load), .out_store(out_store),
    .out_illegal(out_illegal), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [7:0]  alu;
    logic [7:0]  mem;
    logic [7:0]  csr;
    logic        gpr;
    logic        ld;
    logic        st;
    logic        s1;
    logic        s2;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [10];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid       = v;
    in_pc          = pc;
    in_inst        = inst;
    in_inst_enable = ~(32'd1 << inst[6:2]);
  endtask

  initial begin
    int got;
    vecs[0] = '{32'h00500093, 32'h100, 8'hFB, 8'hFF, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h5, 5'd1};
    vecs[1] = '{32'h40208033, 32'h104, 8'hFA, 8'hFF, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0};
    vecs[2] = '{32'h00112223, 32'h108, 8'hFB, 8'hFE, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 5'd4};
    vecs[3] = '{32'h123452B7, 32'h10C, 8'hFB, 8'hFF, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h12345000, 5'd5};
    vecs[4] = '{32'h008000EF, 32'h200, 8'hFB, 8'hFF, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h4, 5'd1};
    vecs[5] = '{32'hFFC12183, 32'h204, 8'hFB, 8'hDF, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFC, 5'd3};
    vecs[6] = '{32'h40325213, 32'h208, 8'hF0, 8'hFF, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h403, 5'd4};
    vecs[7] = '{32'h300022F3, 32'h20C, 8'hF8, 8'hFF, 8'h7B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 5'd5};
    vecs[8] = '{32'h00000073, 32'h210, 8'hF8, 8'hFF, 8'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0};
    vecs[9] = '{32'h00208463, 32'h214, 8'hFA, 8'hFF, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd8};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    in_inst_enable = '1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_op", 32'(out_alu_op), 32'hFF);
    chk("rst_mem_op", 32'(out_mem_op), 32'hFF);
    chk("rst_csr_op", 32'(out_csr_op), 32'hFF);
    chk("rst_gpr_we", 32'(out_gpr_we), 32'd1);
    chk("rst_ld_st", 32'({out_load, out_store}), 32'd3);
    chk("rst_pc", out_pc, 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].inst);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'd1);
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d_alu_op", i), 32'(out_alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_mem_op", i), 32'(out_mem_op), 32'(vecs[i].mem));
      chk($sformatf("v%0d_csr_op", i), 32'(out_csr_op), 32'(vecs[i].csr));
      chk($sformatf("v%0d_gpr_we", i), 32'(out_gpr_we), 32'(vecs[i].gpr));
      chk($sformatf("v%0d_load", i), 32'(out_load), 32'(vecs[i].ld));
      chk($sformatf("v%0d_store", i), 32'(out_store), 32'(vecs[i].st));
      chk($sformatf("v%0d_src1", i), 32'(out_alu_src_1), 32'(vecs[i].s1));
      chk($sformatf("v%0d_src2", i), 32'(out_alu_src_2), 32'(vecs[i].s2));
      chk($sformatf("v%0d_imm1", i), out_alu_imm_1, vecs[i].imm1);
      chk($sformatf("v%0d_imm2", i), out_alu_imm_2, vecs[i].imm2);
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_popped", i), 32'(out_valid), 32'd0);
    end

    // fill with back-pressure, then pop with an offered (refused) push while full
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h40208033);
    @(negedge clk);
    drive(1'b1, 32'h404, 32'h00112223);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_occ", 32'(occupancy), 32'd2);
    chk("fill_head_pc", out_pc, 32'h400);
    chk("fill_rs", 32'({out_rs1, out_rs2}), 32'({5'd1, 5'd2}));
    @(negedge clk);
    chk("hold_pc", out_pc, 32'h400);
    chk("hold_alu_op", 32'(out_alu_op), 32'hFA);
    drive(1'b1, 32'h408, 32'h00500093);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_pop_occ", 32'(occupancy), 32'd1);
    chk("pop2_pc", out_pc, 32'h404);
    chk("pop2_alu_op", 32'(out_alu_op), 32'hFB);
    chk("pop2_mem_op", 32'(out_mem_op), 32'hFE);
    chk("pop2_store", 32'(out_store), 32'd0);
    @(negedge clk);
    chk("full_push_dropped", 32'(out_valid), 32'd0);

    // back-to-back streaming across pointer wrap
    got = 0;
    for (int c = 0; c < 13; c++) begin
      drive(c < 10, 32'h1000 + 32'(c) * 4, 32'h00500093);
      @(negedge clk);
      chk($sformatf("wrap_occ%0d", c), 32'(occupancy <= CNT_W'(1)), 32'd1);
      if (out_valid) begin
        chk($sformatf("wrap_pc%0d", got), out_pc, 32'h1000 + 32'(got) * 4);
        got++;
      end
    end
    chk("wrap_count", 32'(got), 32'd10);

    // flush while full and while offering a new instruction
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h00500093);
    @(negedge clk);
    drive(1'b1, 32'h504, 32'h00500093);
    @(negedge clk);
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    drive(1'b1, 32'h5EE, 32'h00500093);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush_quiet%0d", k), 32'(out_valid), 32'd0);
    end
    drive(1'b1, 32'h600, 32'h00500093);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_flush_pc", out_pc, 32'h600);
    @(negedge clk);

    // reset in mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'h700, 32'h00112223);
    @(negedge clk);
    chk("mid_occ", 32'(occupancy), 32'd1);
    rst = 1'b0;
    drive(1'b1, 32'h704, 32'h00500093);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_alu", 32'(out_alu_op), 32'hFF);
    chk("mid_rst_store", 32'(out_store), 32'd1);
    chk("mid_rst_imm2", out_alu_imm_2, 32'd0);

    // unrecognised encoding with no enable low
    drive(1'b1, 32'h800, 32'hFFFFFFFF);
    in_inst_enable = '1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_flag", 32'(out_illegal), 32'(EXP_ILL));
    chk("ill_gpr_we", 32'(out_gpr_we), 32'd1);
    chk("ill_mem_op", 32'(out_mem_op), 32'hFF);
    chk("ill_alu_op", 32'(out_alu_op), 32'hF8);
    out_ready = 1'b1;
    @(negedge clk);
    // legal opcode enable but low bits wrong
    drive(1'b1, 32'h804, 32'h00500090);
    in_inst_enable = ~(32'd1 << 4);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_lowbits_flag", 32'(out_illegal), 32'(EXP_ILL));
    chk("ill_lowbits_gpr_we", 32'(out_gpr_we), 32'(EXP_ILL));
    out_ready = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_stage_q.md
# id_stage_q

Pipelined, parametrised RV32I instruction-decode stage with a valid/ready handshake and an output queue. It accepts fetched `pc`/`inst` plus the active-low one-hot opcode enables from the fetch-side 74x138 decoders. It produces the full control bundle (ALU sources, immediates, ALU/mem/CSR ops, register indices, write enable) through a DEPTH-entry FIFO. It sits between IF and EX, decoupling them so that EX back-pressure stalls fetch without losing instructions.

## Interface
- `DEPTH`, 2, output queue entries; power of two, ≥2
- `CNT_W`, `$clog2(DEPTH+1)`, occupancy counter width (derived, do not override)
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-low reset
- `flush` in 1, active-high; discards all queued entries
- `in_valid` in 1, upstream has an instruction
- `in_ready` out 1, stage accepts this cycle
- `in_pc` in 32, instruction address
- `in_inst` in 32, instruction word
- `in_inst_enable` in 32, active-low one-hot of `inst[6:2]`
- `out_valid` out 1, head entry valid
- `out_ready` in 1, EX consumes head
- `out_pc` out 32; `out_rd`, `out_rs1`, `out_rs2` out 5 each
- `out_alu_src_1`, `out_alu_src_2` out 1; `out_alu_imm_1`, `out_alu_imm_2` out 32
- `out_alu_op`, `out_mem_op`, `out_csr_op` out 8, active-low
- `out_gpr_we`, `out_load`, `out_store` out 1, active-low
- `out_illegal` out 1, active-high (see Configuration)
- `occupancy` out CNT_W, entries held

## Operation
- Class enables are taken from `in_inst_enable`, all active-low:
  - lui[13], auipc[5], jal[27], jalr[25], branch[24]
  - imm[4], reg[12], load[0], store[8], csr[28]
- Immediates:
  - U = `{inst[31:12],12'b0}`
  - I = sign-extended `inst[31:20]`
  - S = sign-extended `{inst[31:25],inst[11:7]}`
  - The selected immediate is U for lui/auipc, I for load/imm/jalr/jal, S for store, and 0 otherwise.
- Operand selection:
  - `alu_src_1` = AND of load, store, imm, reg, branch.
  - `alu_src_2` = reg & branch.
  - `alu_imm_1` = pc for auipc/jal/jalr, else 0.
  - `alu_imm_2` = 4 for jal/jalr, else the selected immediate.
- `alu_op`:
  - lui/auipc/jal/jalr/load/store → FB (add).
  - branch → FA (sub).
  - imm/reg by funct3:
    - 000 → FB, or FA for reg with inst[30]=1
    - 001 → D8
    - 010 → 7A
    - 011 → BA
    - 100 → FC
    - 101 → E8, or F0 when inst[30]=1
    - 110 → FD
    - 111 → FE
  - Anything else → F8.
- `mem_op`: `{lb,lh,lw,lbu,lhu,sb,sh,sw}`, each low when load/store is active and funct3 matches (load 0,1,2,4,5; store 0,1,2).
- `csr_op`:
  - bit7 = 0
  - bits6:4 = ecall/ebreak/mret, decoded from csr & funct3=0 & inst[22:20] = 0/1/2
  - bits3:1 = csrrw/csrrs/csrrc, from funct3 {1,5}/{2,6}/{3,7}
  - bit0 = ~inst[14]
- `gpr_we` is low when rd≠0 and any of these is active: lui, auipc, jal, jalr, load, imm, reg, csrrw, csrrs, csrrc.
- Decode is combinational on the input side. The decoded bundle is written into the FIFO on push (`in_valid & in_ready`). Pop happens on `out_valid & out_ready`.
- When empty, the output payload is idle:
  - all active-low fields are all-ones
  - all other fields are 0

## Timing
- Reset (rst=0 at an edge):
  - occupancy=0, out_valid=0, in_ready=1
  - outputs idle: alu_op/mem_op/csr_op=FF, gpr_we/load/store=1, all else 0
- Latency: an instruction pushed at edge N is on the outputs with out_valid=1 after edge N (a one-cycle bubble minimum). There is no combinational in→out path.
- `in_ready` = (occupancy < DEPTH), registered-derived; it does not depend on `out_ready`.
- Full with simultaneous pop: in_ready=0, so there is no push that cycle, and occupancy drops by 1.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged and FIFO order is preserved.
- Read/write pointers wrap modulo DEPTH.
- `flush` takes priority over push and pop in the same cycle. After the edge, occupancy=0 and out_valid=0, and the input presented that cycle is dropped.
- rst=0 mid-stream behaves identically to flush and also returns the outputs to idle.
- Outputs are stable while out_valid=1 and out_ready=0.

## Configuration
- `ID_ILLEGAL_TRAP_EN` defined:
  - An entry is marked illegal when no recognised enable bit is low, or when inst[1:0]≠2'b11.
  - For an illegal entry: out_illegal=1, gpr_we=1, mem_op=FF, load=1, store=1, csr_op[7:1]=7'h7F.
  - The illegal flag is queued with the entry.
- `ID_ILLEGAL_TRAP_EN` undefined:
  - out_illegal is tied 0.
  - No gating is applied; unrecognised encodings decode to the "otherwise" values above.

## Test plan
- Reset then idle:
  - Stimulus: rst=0 for 2 cycles, then rst=1, no input.
  - Required: occupancy=0, out_valid=0, in_ready=1, alu_op=FF, gpr_we=1.
- Single instruction:
  - Stimulus: push `addi x1,x0,5` (0x00500093, enable bit4 low), pc=0x100.
  - Required one cycle later: out_valid=1, alu_op=FB, alu_imm_2=5, alu_src_1=0, alu_src_2=1, gpr_we=0, rd=1.
- Fill and back-pressure (DEPTH=2):
  - Stimulus: push `sub` (0x40208033), then `sw` (0x00112223), out_ready=0.
  - Required: in_ready=0 and occupancy=2.
  - Then raise out_ready: pop order is alu_op FA (sub), then FB (sw) with mem_op=FE and store=0.
- Wrap-around:
  - Stimulus: 10 back-to-back pushes with out_ready=1 throughout.
  - Required: every pc emerges in order, with occupancy ≤1 at all times.
- Flush with push:
  - Stimulus: occupancy=2, assert flush while in_valid=1.
  - Required next cycle: occupancy=0, out_valid=0, and the flushed instruction never appears.
- Illegal (macro on):
  - Stimulus: push 0xFFFFFFFF with all enables high.
  - Required: out_illegal=1, gpr_we=1, mem_op=FF.
  - With the macro off, out_illegal stays 0.
